// File: rtl/controle_irrigacao.sv
// -----------------------------------------------------------------------------
// controle_irrigacao
// Sequencer for the irrigation countdown datapath (preset generator plus a BCD
// mm:ss counter chain). Debounces the start/stop button and reads the
// thermometer-coded moisture sensor to choose a mode. It then drives the preset
// selects and the timer load/run strobes, and opens the matching valve until the
// timer reads 00:00. It also handles rain pause, manual stop, invalid sensor
// codes and a cycle counter.
//
// Optional feature: define RECHECK_EN to stop an irrigation early when the
// sensor reads fully wet (niveis == 111) for two consecutive IRRIGA cycles.
//
// Ports
//   clock, reset_n      clock (rising edge) and async active-low reset
//   botao               raw start/stop button level
//   chuva               rain sensor, 1 = raining
//   niveis[2:0]         moisture thermometer code ([0]=low .. [2]=high wet)
//   timer_zero          counter chain reads 00:00
//   aspersao            preset select: sprinkler
//   gotejamento         preset select: drip
//   casoEspecifico      preset select: extended (soil fully dry)
//   timer_load          one-cycle preset load strobe
//   timer_en            countdown enable
//   valv_asp, valv_got  sprinkler / drip valves
//   fim                 one-cycle end-of-cycle pulse
//   erro                invalid sensor code, held until a valid start
//   ciclos[CNT_W-1:0]   completed irrigation cycles (wraps)
// -----------------------------------------------------------------------------
module controle_irrigacao #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             botao,
    input  logic             chuva,
    input  logic [2:0]       niveis,
    input  logic             timer_zero,
    output logic             aspersao,
    output logic             gotejamento,
    output logic             casoEspecifico,
    output logic             timer_load,
    output logic             timer_en,
    output logic             valv_asp,
    output logic             valv_got,
    output logic             fim,
    output logic             erro,
    output logic [CNT_W-1:0] ciclos
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        IRRIGA  = 3'd2,
        PAUSA   = 3'd3,
        FIM     = 3'd4,
        ERRO    = 3'd5
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic [DEB_W-1:0] deb_cnt;
    logic             deb_level;
    logic             deb_level_d;
    logic             start_evt;

    logic       asp_nxt;
    logic       got_nxt;
    logic       ce_nxt;
    logic       skip_fim;
    logic       recheck;

    // Debouncer: accept a new level after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            deb_cnt     <= '0;
            deb_level   <= 1'b0;
            deb_level_d <= 1'b0;
        end else begin
            deb_level_d <= deb_level;
            if (botao != deb_level) begin
                if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                    deb_level <= botao;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign start_evt = deb_level & ~deb_level_d;

`ifdef RECHECK_EN
    logic wet_q;

    // Remembers that the previous IRRIGA cycle already read fully wet
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wet_q <= 1'b0;
        end else begin
            wet_q <= (state == IRRIGA) && (niveis == 3'b111);
        end
    end

    assign recheck = wet_q && (niveis == 3'b111);
`else
    assign recheck = 1'b0;
`endif

    // Next-state and next mode selection
    always_comb begin
        state_nxt = state;
        asp_nxt   = aspersao;
        got_nxt   = gotejamento;
        ce_nxt    = casoEspecifico;
        skip_fim  = 1'b0;
        case (state)
            OCIOSO, ERRO: begin
                if (start_evt) begin
                    case (niveis)
                        3'b000: begin
                            state_nxt = CARREGA;
                            asp_nxt   = 1'b1;
                            got_nxt   = 1'b0;
                            ce_nxt    = 1'b1;
                        end
                        3'b001: begin
                            state_nxt = CARREGA;
                            asp_nxt   = 1'b1;
                            got_nxt   = 1'b0;
                            ce_nxt    = 1'b0;
                        end
                        3'b011: begin
                            state_nxt = CARREGA;
                            asp_nxt   = 1'b0;
                            got_nxt   = 1'b1;
                            ce_nxt    = 1'b0;
                        end
                        3'b111: begin
                            // Soil already wet: report an empty cycle, do not count it
                            state_nxt = OCIOSO;
                            skip_fim  = 1'b1;
                        end
                        default: state_nxt = ERRO;
                    endcase
                end
            end
            CARREGA: state_nxt = IRRIGA;
            IRRIGA: begin
                if (timer_zero)     state_nxt = FIM;
                else if (recheck)   state_nxt = FIM;
                else if (start_evt) state_nxt = FIM;
                else if (chuva)     state_nxt = PAUSA;
            end
            PAUSA: begin
                if (start_evt)  state_nxt = FIM;
                else if (!chuva) state_nxt = IRRIGA;
            end
            FIM:     state_nxt = OCIOSO;
            default: state_nxt = OCIOSO;
        endcase
        // Mode bits live only from CARREGA through FIM
        if ((state_nxt == OCIOSO) || (state_nxt == ERRO)) begin
            asp_nxt = 1'b0;
            got_nxt = 1'b0;
            ce_nxt  = 1'b0;
        end
    end

    // State register and outputs decoded from the next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= OCIOSO;
            aspersao       <= 1'b0;
            gotejamento    <= 1'b0;
            casoEspecifico <= 1'b0;
            timer_load     <= 1'b0;
            timer_en       <= 1'b0;
            valv_asp       <= 1'b0;
            valv_got       <= 1'b0;
            fim            <= 1'b0;
            erro           <= 1'b0;
            ciclos         <= '0;
        end else begin
            state          <= state_nxt;
            aspersao       <= asp_nxt;
            gotejamento    <= got_nxt;
            casoEspecifico <= ce_nxt;
            timer_load     <= (state_nxt == CARREGA);
            timer_en       <= (state_nxt == IRRIGA);
            valv_asp       <= (state_nxt == IRRIGA) && asp_nxt;
            valv_got       <= (state_nxt == IRRIGA) && got_nxt;
            fim            <= (state_nxt == FIM) || skip_fim;
            erro           <= (state_nxt == ERRO);
            if (state_nxt == FIM) begin
                ciclos <= ciclos + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_controle_irrigacao.sv
// Directed bench for controle_irrigacao (default parameters).
module tb_controle_irrigacao;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       botao;
    logic       chuva;
    logic [2:0] niveis;
    logic       timer_zero;
    logic       aspersao;
    logic       gotejamento;
    logic       casoEspecifico;
    logic       timer_load;
    logic       timer_en;
    logic       valv_asp;
    logic       valv_got;
    logic       fim;
    logic       erro;
    logic [7:0] ciclos;

    int checks = 0;
    int errors = 0;

    controle_irrigacao dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .botao          (botao),
        .chuva          (chuva),
        .niveis         (niveis),
        .timer_zero     (timer_zero),
        .aspersao       (aspersao),
        .gotejamento    (gotejamento),
        .casoEspecifico (casoEspecifico),
        .timer_load     (timer_load),
        .timer_en       (timer_en),
        .valv_asp       (valv_asp),
        .valv_got       (valv_got),
        .fim            (fim),
        .erro           (erro),
        .ciclos         (ciclos)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge; invariants every cycle
    task automatic tick();
        @(posedge clock);
        #1;
        chk("inv_valves", 32'(valv_asp & valv_got), 0);
        chk("inv_timer", 32'(timer_load & timer_en), 0);
    endtask

    // Press start with the given code; returns in IRRIGA with the button released
    task automatic start_to_irriga(input logic [2:0] nv);
        niveis = nv;
        botao  = 1'b1;
        repeat (5) tick();
        chk("s2i_load", 32'(timer_load), 1);
        botao = 1'b0;
        tick();
        chk("s2i_en", 32'(timer_en), 1);
        repeat (3) tick();
    endtask

    initial begin
        reset_n    = 1'b0;
        botao      = 1'b0;
        chuva      = 1'b0;
        niveis     = 3'b001;
        timer_zero = 1'b0;
        repeat (3) tick();
        chk("rst_outs", {22'd0, aspersao, gotejamento, casoEspecifico, timer_load,
                         timer_en, valv_asp, valv_got, fim, erro}, 0);
        chk("rst_ciclos", 32'(ciclos), 0);
        reset_n = 1'b1;
        tick();

        // 1: sprinkler cycle ended by timer_zero
        niveis = 3'b001;
        botao  = 1'b1;
        repeat (4) tick();
        chk("t1_no_load_yet", 32'(timer_load), 0);
        tick();
        chk("t1_load", 32'(timer_load), 1);
        chk("t1_asp_sel", 32'(aspersao), 1);
        chk("t1_ce_sel", 32'(casoEspecifico), 0);
        chk("t1_valve_closed", 32'(valv_asp), 0);
        tick();
        botao = 1'b0;
        chk("t1_load_done", 32'(timer_load), 0);
        chk("t1_en", 32'(timer_en), 1);
        chk("t1_valv_asp", 32'(valv_asp), 1);
        chk("t1_valv_got", 32'(valv_got), 0);
        repeat (3) tick();
        chk("t1_running", 32'(timer_en), 1);
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        chk("t1_fim", 32'(fim), 1);
        chk("t1_ciclos", 32'(ciclos), 1);
        chk("t1_valve_off", 32'(valv_asp), 0);
        chk("t1_en_off", 32'(timer_en), 0);
        tick();
        chk("t1_fim_pulse", 32'(fim), 0);
        chk("t1_mode_clr", 32'(aspersao), 0);

        // 2: drip cycle with rain pause
        start_to_irriga(3'b011);
        chk("t2_valv_got", 32'(valv_got), 1);
        chk("t2_got_sel", 32'(gotejamento), 1);
        chuva = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_pause_valve", 32'(valv_got), 0);
            chk("t2_pause_en", 32'(timer_en), 0);
            chk("t2_pause_load", 32'(timer_load), 0);
        end
        chuva = 1'b0;
        tick();
        chk("t2_resume_valve", 32'(valv_got), 1);
        chk("t2_resume_en", 32'(timer_en), 1);
        chk("t2_resume_noload", 32'(timer_load), 0);
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        chk("t2_fim", 32'(fim), 1);
        chk("t2_ciclos", 32'(ciclos), 2);
        tick();

        // 3: invalid code, then recovery with fully dry soil
        niveis = 3'b101;
        botao  = 1'b1;
        repeat (5) tick();
        chk("t3_erro", 32'(erro), 1);
        chk("t3_valves", 32'({valv_asp, valv_got}), 0);
        chk("t3_noload", 32'(timer_load), 0);
        botao = 1'b0;
        repeat (4) tick();
        chk("t3_erro_sticky", 32'(erro), 1);
        niveis = 3'b000;
        botao  = 1'b1;
        repeat (5) tick();
        chk("t3_erro_clr", 32'(erro), 0);
        chk("t3_asp", 32'(aspersao), 1);
        chk("t3_ce", 32'(casoEspecifico), 1);
        chk("t3_load", 32'(timer_load), 1);
        botao = 1'b0;
        tick();
        chk("t3_valv_asp", 32'(valv_asp), 1);
        repeat (3) tick();

        // 4: manual stop during IRRIGA
        botao = 1'b1;
        repeat (4) tick();
        chk("t4_still_run", 32'(timer_en), 1);
        tick();
        chk("t4_stop_fim", 32'(fim), 1);
        chk("t4_stop_ciclos", 32'(ciclos), 3);
        chk("t4_stop_valve", 32'(valv_asp), 0);
        botao = 1'b0;
        tick();
        chk("t4_stop_mode_clr", 32'({aspersao, casoEspecifico}), 0);
        repeat (3) tick();

        // 4: short glitch is ignored
        niveis = 3'b001;
        botao  = 1'b1;
        repeat (2) tick();
        botao = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_glitch_load", 32'(timer_load), 0);
            chk("t4_glitch_en", 32'(timer_en), 0);
        end

        // 4: timer_zero and press on the same cycle give a single fim
        start_to_irriga(3'b001);
        botao = 1'b1;
        repeat (4) tick();
        timer_zero = 1'b1;
        tick();
        chk("t4_same_fim", 32'(fim), 1);
        chk("t4_same_ciclos", 32'(ciclos), 4);
        timer_zero = 1'b0;
        botao      = 1'b0;
        tick();
        chk("t4_same_single", 32'(fim), 0);
        tick();
        chk("t4_same_ciclos2", 32'(ciclos), 4);
        chk("t4_same_noload", 32'(timer_load), 0);
        repeat (2) tick();

        // Wet soil at start: fim pulse, no count
        niveis = 3'b111;
        botao  = 1'b1;
        repeat (5) tick();
        chk("wet_fim", 32'(fim), 1);
        chk("wet_ciclos", 32'(ciclos), 4);
        chk("wet_noload", 32'(timer_load), 0);
        botao = 1'b0;
        tick();
        chk("wet_fim_pulse", 32'(fim), 0);
        repeat (3) tick();

        // 6: wet reading during IRRIGA
        start_to_irriga(3'b011);
        niveis = 3'b111;
        tick();
        chk("t6_first_wet", 32'(fim), 0);
        tick();
`ifdef RECHECK_EN
        chk("t6_early_fim", 32'(fim), 1);
        chk("t6_early_ciclos", 32'(ciclos), 5);
        tick();
`else
        chk("t6_no_early_fim", 32'(fim), 0);
        chk("t6_still_run", 32'(timer_en), 1);
        timer_zero = 1'b1;
        tick();
        timer_zero = 1'b0;
        chk("t6_fim", 32'(fim), 1);
        chk("t6_ciclos", 32'(ciclos), 5);
        tick();
`endif
        niveis = 3'b001;

        // 5: reset during IRRIGA closes valves at once
        start_to_irriga(3'b001);
        chk("t5_pre_valve", 32'(valv_asp), 1);
        reset_n = 1'b0;
        #2;
        chk("t5_async_valve", 32'(valv_asp), 0);
        chk("t5_async_en", 32'(timer_en), 0);
        chk("t5_async_ciclos", 32'(ciclos), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        chk("t5_after_rst", {22'd0, aspersao, gotejamento, casoEspecifico, timer_load,
                             timer_en, valv_asp, valv_got, fim, erro}, 0);

        // 5: ciclos wraps after 256 completed cycles (00:00 preset)
        timer_zero = 1'b1;
        niveis     = 3'b001;
        for (int n = 0; n < 255; n++) begin
            botao = 1'b1;
            repeat (5) tick();
            botao = 1'b0;
            repeat (4) tick();
        end
        chk("t5_ciclos_255", 32'(ciclos), 255);
        botao = 1'b1;
        repeat (5) tick();
        chk("t5_wrap_load", 32'(timer_load), 1);
        botao = 1'b0;
        tick();
        chk("t5_zero_preset_run", 32'(valv_asp), 1);
        tick();
        chk("t5_zero_preset_fim", 32'(fim), 1);
        chk("t5_wrap_ciclos", 32'(ciclos), 0);
        timer_zero = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
